// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   MDU_WIDTH      default operand / HI / LO width (only 32 is supported)
//   OP_*           encodings of the 3-bit op port (6 and 7 are no-ops)
//   state_t        iteration FSM states
//   is_muldiv_op / is_div_op / is_signed_op   op decode helpers
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_muldiv_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_sign.sv
// mdu_sign: combinational two-lane conditional negate.
// Used as the operand pre-step (absolute value of a and b, with their signs)
// and as the result post-step (sign fix-up of product or quotient/remainder).
//   hi_in, lo_in    lane inputs
//   neg_hi, neg_lo  negate enables per lane
//   wide            treat {hi_in, lo_in} as one 2*WIDTH value negated by neg_hi
//   hi_out, lo_out  lane outputs
//   hi_sign, lo_sign  MSB of each input lane
module mdu_sign #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             neg_hi,
    input  logic             neg_lo,
    input  logic             wide,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             hi_sign,
    output logic             lo_sign
);

    logic [2*WIDTH-1:0] joined;
    logic [2*WIDTH-1:0] joined_neg;

    assign joined     = {hi_in, lo_in};
    assign joined_neg = -joined;
    assign hi_sign    = hi_in[WIDTH-1];
    assign lo_sign    = lo_in[WIDTH-1];

    always_comb begin
        hi_out = hi_in;
        lo_out = lo_in;
        if (wide) begin
            // 64-bit product: the borrow must ripple across the lane boundary
            if (neg_hi) begin
                {hi_out, lo_out} = joined_neg;
            end
        end else begin
            if (neg_hi) begin
                hi_out = -hi_in;
            end
            if (neg_lo) begin
                lo_out = -lo_in;
            end
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit with HI/LO registers.
// MULT/MULTU/DIV/DIVU take 33 cycles (32 RUN iterations + FIX), MTHI/MTLO
// write in one cycle.
//   clk, rst   clock, asynchronous active-high reset
//   start, op  issue strobe and operation
//   a, b       rs / rt operands
//   hi, lo     architectural HI / LO registers
//   busy       operation in flight (registered)
//   done       one-cycle pulse after HI/LO commit (registered)
//   dz         combinational divide-by-zero flag for the issuing cycle
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t state_next;

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               run_div;
    logic               neg_res;
    logic               neg_rem;

    // FSM output controls
    logic accept;
    logic load;
    logic step;
    logic commit;
    logic busy_next;
    logic done_next;

    // operand pre-step
    logic             op_signed;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             sign_a;
    logic             sign_b;

    // result post-step
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic [1:0]       post_signs_unused;

    // iteration datapath
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shifted;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    assign op_signed = is_signed_op(op);

    mdu_sign #(.WIDTH(WIDTH)) u_pre (
        .hi_in   (a),
        .lo_in   (b),
        .neg_hi  (op_signed & a[WIDTH-1]),
        .neg_lo  (op_signed & b[WIDTH-1]),
        .wide    (1'b0),
        .hi_out  (abs_a),
        .lo_out  (abs_b),
        .hi_sign (sign_a),
        .lo_sign (sign_b)
    );

    mdu_sign #(.WIDTH(WIDTH)) u_post (
        .hi_in   (acc[2*WIDTH-1:WIDTH]),
        .lo_in   (acc[WIDTH-1:0]),
        .neg_hi  (run_div ? neg_rem : neg_res),
        .neg_lo  (neg_res),
        .wide    (~run_div),
        .hi_out  (res_hi),
        .lo_out  (res_lo),
        .hi_sign (post_signs_unused[1]),
        .lo_sign (post_signs_unused[0])
    );

    // Multiply: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole register right. After 32
    // steps every partial product has landed at its proper weight.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (opb[0] ? opa : '0)};

    // Divide: the partial remainder is always below the divisor, so the
    // shifted value is below twice the divisor and bit WIDTH of the 33-bit
    // trial difference is a clean borrow.
    assign div_shifted = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
    assign div_trial   = div_shifted - {1'b0, opb};
    assign div_ge      = ~div_trial[WIDTH];
    assign div_rem     = div_ge ? div_trial[WIDTH-1:0] : div_shifted[WIDTH-1:0];

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = RUN;
            RUN:     if (count == LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // output / control logic
    always_comb begin
        accept    = start & ~busy;
        dz        = accept & is_div_op(op) & (b == '0);
        load      = accept & is_muldiv_op(op) & ~dz;
        step      = (state == RUN);
        commit    = (state == FIX);
        busy_next = (state_next != IDLE);
        done_next = commit;
    end

    // datapath, HI/LO and registered status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            acc     <= '0;
            opa     <= '0;
            opb     <= '0;
            run_div <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;

            if (load) begin
                count   <= '0;
                acc     <= '0;
                opa     <= abs_a;
                opb     <= abs_b;
                run_div <= is_div_op(op);
                neg_res <= op_signed & (sign_a ^ sign_b);
                neg_rem <= op_signed & sign_a;
            end else if (step) begin
                count <= count + 1'b1;
                if (run_div) begin
                    acc <= {div_rem, acc[WIDTH-2:0], div_ge};
                    opa <= {opa[WIDTH-2:0], 1'b0};
                end else begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                    opb <= {1'b0, opb[WIDTH-1:1]};
                end
            end

            if (commit) begin
                hi <= res_hi;
                lo <= res_lo;
            end

            if (accept && op == OP_MTHI) begin
                hi <= a;
            end
            if (accept && op == OP_MTLO) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random stimulus for mul_div_unit, checked
// against an arithmetic model of HI/LO/busy/done/dz kept in the bench.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        dz;

    int vectors = 0;
    int miscompares = 0;

    // model state
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_pend;
    int          m_rem;
    logic        m_done;
    logic        m_acc;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {HI, LO} an accepted multiply/divide must produce
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        logic [63:0] q;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0:    return sx * sy;
            3'd1:    return {32'b0, x} * {32'b0, y};
            3'd2: begin
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: return {x % y, x / y};
        endcase
    endfunction

    // behavioural model: a mul/div occupies the unit for 33 edges, then
    // commits its result with a done pulse
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hi   = '0;
            m_lo   = '0;
            m_pend = '0;
            m_rem  = 0;
            m_done = 1'b0;
        end else begin
            m_acc  = start && (m_rem == 0);
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end
            if (m_acc) begin
                case (op)
                    3'd0, 3'd1: begin
                        m_pend = ref_result(op, a, b);
                        m_rem  = 33;
                    end
                    3'd2, 3'd3: begin
                        if (b != 0) begin
                            m_pend = ref_result(op, a, b);
                            m_rem  = 33;
                        end
                    end
                    3'd4:    m_hi = a;
                    3'd5:    m_lo = a;
                    default: ;
                endcase
            end
        end
    end

    // compare process: registered outputs against the model every cycle
    always @(posedge clk) begin
        #2;
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("busy", 32'(busy), 32'(m_rem > 0));
        check("done", 32'(done), 32'(m_done));
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = s;
        op    = o;
        a     = x;
        b     = y;
        #1;
        check("dz", 32'(dz), 32'(s && (m_rem == 0) && (o == 3'd2 || o == 3'd3) && (y == 0)));
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        drive(1'b1, o, x, y);
        drive(1'b0, 3'd0, $urandom, $urandom);
        check("busy_after_issue", 32'(busy), 32'd1);
    endtask

    task automatic wait_commit(input int n, input string name, input logic [31:0] eh, input logic [31:0] el);
        repeat (n) @(posedge clk);
        #1;
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        wait_commit(33, "mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_commit(33, "multu", 32'hFFFF_FFFE, 32'h0000_0001);
        issue(3'd3, 32'd100, 32'd7);
        wait_commit(33, "divu", 32'd2, 32'd14);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_commit(33, "div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_commit(33, "div_ovf", 32'h0, 32'h8000_0000);

        // divide by zero: flagged, not executed
        drive(1'b1, 3'd4, 32'h11, 32'h0);
        drive(1'b1, 3'd5, 32'h22, 32'h0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, (k == 0) ? 3'd2 : 3'd3, 32'd5, 32'd0);
            check("dz_flag", 32'(dz), 32'd1);
            drive(1'b0, 3'd0, 32'd0, 32'd0);
            check("dz_busy", 32'(busy), 32'd0);
            repeat (3) drive(1'b0, 3'd0, 32'd0, 32'd0);
            check("dz_hi", hi, 32'h11);
            check("dz_lo", lo, 32'h22);
        end

        // MTHI / MTLO visible the cycle after accept
        drive(1'b1, 3'd4, 32'hDEAD_BEEF, 32'd0);
        drive(1'b1, 3'd5, 32'h1234_5678, 32'd0);
        check("mthi", hi, 32'hDEAD_BEEF);
        check("mthi_busy", 32'(busy), 32'd0);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        check("mtlo", lo, 32'h1234_5678);
        check("mtlo_busy", 32'(busy), 32'd0);

        // starts while busy are ignored
        issue(3'd0, 32'd6, 32'd7);
        repeat (8) drive(1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 3'd4, 32'hAAAA_AAAA, 32'd0);
        drive(1'b1, 3'd2, 32'd5, 32'd0);
        check("busy_dz", 32'(dz), 32'd0);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        check("busy_mthi", hi, 32'hDEAD_BEEF);
        wait_commit(22, "inflight", 32'h0, 32'd42);

        // reset aborts an operation in flight
        issue(3'd2, 32'd1000, 32'd3);
        repeat (13) drive(1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) drive(1'b0, 3'd0, 32'd0, 32'd0);
        issue(3'd3, 32'd9, 32'd3);
        wait_commit(33, "after_rst", 32'h0, 32'd3);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), pick(), pick());
        end
        repeat (40) drive(1'b0, 3'd0, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
